yolcu_sirasi: RTL and testbench

//  Passenger queue directly upstream of the airport check-in pipeline.
//  - Buffers passenger records (kimlik_no, uyruk, agirlik, bakiye) arriving from the entry desk.
//  - Presents one record at a time to the kimlik/bavul/odeme/ucak chain.
//  - Holds each record stable for a fixed processing round, then advances to the next.

---
 rtl/havalimani_pkg.sv | 27 ++
 rtl/yolcu_sirasi_if.sv | 55 +++++
 rtl/yolcu_fifo.sv | 97 +++++++++
 rtl/yolcu_sirasi.sv | 193 +++++++++++++++++++
 tb/tb_yolcu_sirasi.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/havalimani_pkg.sv
// rtl/havalimani_pkg.sv - shared types and widths for the airport passenger queue
//
// Purpose:
//   Common definitions used by the passenger queue, its FIFO and its interface:
//   the presentation FSM state encoding, the fixed record field widths and a
//   helper that gives the packed passenger record width for a given BIT.
// Contents:
//   durum_t          - FSM states BOS (idle, nothing presented) and SUNUM (presenting)
//   AGIRLIK_W        - baggage weight field width
//   BAKIYE_W         - balance field width
//   kayit_genisligi  - packed record width {kimlik_no, uyruk, agirlik, bakiye} = BIT+16

package havalimani_pkg;

  typedef enum logic {
    BOS   = 1'b0,
    SUNUM = 1'b1
  } durum_t;

  localparam int AGIRLIK_W = 6;
  localparam int BAKIYE_W  = 9;

  function automatic int kayit_genisligi(input int bit_w);
    return bit_w + 1 + AGIRLIK_W + BAKIYE_W;
  endfunction

endpackage

// File: rtl/yolcu_sirasi_if.sv
// rtl/yolcu_sirasi_if.sv - entry-desk / airport-chain signal bundle of the passenger queue
//
// Purpose:
//   Groups the write side (from the entry desk) and the presentation side
//   (to the kimlik/bavul/odeme/ucak chain) of the passenger queue.
// Signals:
//   yaz, kimlik_no_g, uyruk_g, agirlik_g, bakiye_g  - incoming record and write request
//   dolu, bos, doluluk                              - FIFO status
//   kimlik_no, uyruk, agirlik, bakiye               - presented record
//   yolcu_gecerli, tur_basi                         - presentation valid / first-cycle pulse
//   tasma, hizmet_sayisi                            - sticky overflow / served passenger count
// Modports:
//   master - entry desk and downstream observer (drives the write side)
//   slave  - the queue itself (drives status and presentation)

interface yolcu_sirasi_if #(
  parameter int BIT           = 6,
  parameter int DERINLIK_LOG2 = 2
);
  import havalimani_pkg::*;

  logic                     yaz;
  logic [BIT-1:0]           kimlik_no_g;
  logic                     uyruk_g;
  logic [AGIRLIK_W-1:0]     agirlik_g;
  logic [BAKIYE_W-1:0]      bakiye_g;

  logic                     dolu;
  logic                     bos;
  logic [DERINLIK_LOG2:0]   doluluk;

  logic [BIT-1:0]           kimlik_no;
  logic                     uyruk;
  logic [AGIRLIK_W-1:0]     agirlik;
  logic [BAKIYE_W-1:0]      bakiye;
  logic                     yolcu_gecerli;
  logic                     tur_basi;
  logic                     tasma;
  logic [7:0]               hizmet_sayisi;

  modport master (
    output yaz, kimlik_no_g, uyruk_g, agirlik_g, bakiye_g,
    input  dolu, bos, doluluk,
    input  kimlik_no, uyruk, agirlik, bakiye, yolcu_gecerli, tur_basi,
    input  tasma, hizmet_sayisi
  );

  modport slave (
    input  yaz, kimlik_no_g, uyruk_g, agirlik_g, bakiye_g,
    output dolu, bos, doluluk,
    output kimlik_no, uyruk, agirlik, bakiye, yolcu_gecerli, tur_basi,
    output tasma, hizmet_sayisi
  );

endinterface

// File: rtl/yolcu_fifo.sv
// rtl/yolcu_fifo.sv - parameterised synchronous FIFO holding queued passenger records
//
// Purpose:
//   Stores up to 2**DERINLIK_LOG2 records of W bits. Writes are accepted only
//   when not full and pops only when not empty; the full test uses the
//   registered flag, so a write into a full FIFO is dropped even if a pop
//   happens on the same edge.
// Ports:
//   saat       in   clock
//   reset      in   asynchronous active-low reset
//   yaz_i      in   write request
//   veri_i     in   record to append at the tail
//   oku_i      in   pop request
//   veri_o     out  record at the head (valid while bos_o=0)
//   dolu_o     out  registered full flag
//   bos_o      out  registered empty flag
//   doluluk_o  out  stored entry count

module yolcu_fifo #(
  parameter int W             = 22,
  parameter int DERINLIK_LOG2 = 2
) (
  input  logic                   saat,
  input  logic                   reset,
  input  logic                   yaz_i,
  input  logic [W-1:0]           veri_i,
  input  logic                   oku_i,
  output logic [W-1:0]           veri_o,
  output logic                   dolu_o,
  output logic                   bos_o,
  output logic [DERINLIK_LOG2:0] doluluk_o
);

  localparam int DERINLIK = 1 << DERINLIK_LOG2;
  localparam logic [DERINLIK_LOG2:0] DOLU_SAYI = DERINLIK[DERINLIK_LOG2:0];

  logic [W-1:0]             bellek_q [DERINLIK];
  logic [DERINLIK_LOG2-1:0] yaz_ptr_q, yaz_ptr_d;
  logic [DERINLIK_LOG2-1:0] oku_ptr_q, oku_ptr_d;
  logic [DERINLIK_LOG2:0]   sayi_q, sayi_d;
  logic                     dolu_q, dolu_d;
  logic                     bos_q, bos_d;
  logic                     yaz_ok;
  logic                     oku_ok;

  assign yaz_ok = yaz_i & ~dolu_q;
  assign oku_ok = oku_i & ~bos_q;

  always_comb begin
    yaz_ptr_d = yaz_ptr_q;
    oku_ptr_d = oku_ptr_q;
    sayi_d    = sayi_q;
    if (yaz_ok) begin
      yaz_ptr_d = yaz_ptr_q + DERINLIK_LOG2'(1);
    end
    if (oku_ok) begin
      oku_ptr_d = oku_ptr_q + DERINLIK_LOG2'(1);
    end
    // Simultaneous write and pop leave the count unchanged.
    case ({yaz_ok, oku_ok})
      2'b10:   sayi_d = sayi_q + (DERINLIK_LOG2 + 1)'(1);
      2'b01:   sayi_d = sayi_q - (DERINLIK_LOG2 + 1)'(1);
      default: sayi_d = sayi_q;
    endcase
    dolu_d = (sayi_d == DOLU_SAYI);
    bos_d  = (sayi_d == '0);
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      sayi_q    <= '0;
      dolu_q    <= 1'b0;
      bos_q     <= 1'b1;
    end else begin
      yaz_ptr_q <= yaz_ptr_d;
      oku_ptr_q <= oku_ptr_d;
      sayi_q    <= sayi_d;
      dolu_q    <= dolu_d;
      bos_q     <= bos_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge saat) begin
    if (yaz_ok) begin
      bellek_q[yaz_ptr_q] <= veri_i;
    end
  end

  assign veri_o    = bellek_q[oku_ptr_q];
  assign dolu_o    = dolu_q;
  assign bos_o     = bos_q;
  assign doluluk_o = sayi_q;

endmodule

// File: rtl/yolcu_sirasi.sv
// rtl/yolcu_sirasi.sv - passenger queue presenting one record per fixed round to the check-in chain
//
// Purpose:
//   Buffers passenger records from the entry desk in a FIFO and presents them
//   one at a time, each held stable for TUR_SURESI cycles. Rounds follow each
//   other back-to-back while records are available; otherwise the outputs
//   return to zero and the FSM idles in BOS.
// Optional feature (macro YOLCU_SAYAC_EN):
//   defined   - hizmet_sayisi counts completed presentations (wraps at 255)
//   undefined - counter omitted, hizmet_sayisi tied to zero
// Ports:
//   saat   in   clock, all state updates on the rising edge
//   reset  in   asynchronous active-low reset
//   bus    slave modport of yolcu_sirasi_if (write side, status, presented record)
// Parameters:
//   BIT            kimlik_no width
//   DERINLIK_LOG2  log2 of FIFO depth
//   TUR_SURESI     presentation length in cycles, 1..255

module yolcu_sirasi #(
  parameter int BIT           = 6,
  parameter int DERINLIK_LOG2 = 2,
  parameter int TUR_SURESI    = 4
) (
  input  logic           saat,
  input  logic           reset,
  yolcu_sirasi_if.slave  bus
);
  import havalimani_pkg::*;

  localparam int         KAYIT_W     = kayit_genisligi(BIT);
  localparam logic [7:0] SAYAC_YUKLE = 8'(TUR_SURESI - 1);

  logic [KAYIT_W-1:0]       giris_kaydi;
  logic [KAYIT_W-1:0]       bas_kaydi;
  logic [KAYIT_W-1:0]       yukle_kaydi;
  logic                     fifo_yaz;
  logic                     fifo_oku;
  logic                     fifo_dolu;
  logic                     fifo_bos;
  logic [DERINLIK_LOG2:0]   fifo_doluluk;
  logic                     yukle;
  logic                     atla;

  durum_t                   durum_q, durum_d;
  logic [7:0]               sayac_q, sayac_d;
  logic [BIT-1:0]           kimlik_q, kimlik_d;
  logic                     uyruk_q, uyruk_d;
  logic [AGIRLIK_W-1:0]     agirlik_q, agirlik_d;
  logic [BAKIYE_W-1:0]      bakiye_q, bakiye_d;
  logic                     gecerli_q, gecerli_d;
  logic                     tur_basi_q, tur_basi_d;
  logic                     tasma_q, tasma_d;
`ifdef YOLCU_SAYAC_EN
  logic [7:0]               hizmet_q, hizmet_d;
`endif

  assign giris_kaydi = {bus.kimlik_no_g, bus.uyruk_g, bus.agirlik_g, bus.bakiye_g};

  // A record arriving into an empty FIFO on a round-ending edge bypasses the
  // FIFO and goes straight to the outputs, so it is not stored as well.
  assign fifo_yaz = bus.yaz & ~atla;

  yolcu_fifo #(
    .W             (KAYIT_W),
    .DERINLIK_LOG2 (DERINLIK_LOG2)
  ) u_fifo (
    .saat      (saat),
    .reset     (reset),
    .yaz_i     (fifo_yaz),
    .veri_i    (giris_kaydi),
    .oku_i     (fifo_oku),
    .veri_o    (bas_kaydi),
    .dolu_o    (fifo_dolu),
    .bos_o     (fifo_bos),
    .doluluk_o (fifo_doluluk)
  );

  always_comb begin
    durum_d     = durum_q;
    sayac_d     = sayac_q;
    kimlik_d    = kimlik_q;
    uyruk_d     = uyruk_q;
    agirlik_d   = agirlik_q;
    bakiye_d    = bakiye_q;
    gecerli_d   = gecerli_q;
    tur_basi_d  = 1'b0;
    fifo_oku    = 1'b0;
    atla        = 1'b0;
    yukle       = 1'b0;
    yukle_kaydi = bas_kaydi;
    // Overflow uses the registered full flag, before any same-edge pop.
    tasma_d     = tasma_q | (bus.yaz & fifo_dolu);
`ifdef YOLCU_SAYAC_EN
    hizmet_d    = hizmet_q;
`endif

    case (durum_q)
      BOS: begin
        if (!fifo_bos) begin
          fifo_oku = 1'b1;
          yukle    = 1'b1;
        end
      end
      SUNUM: begin
        if (sayac_q != 8'd0) begin
          sayac_d = sayac_q - 8'd1;
        end else begin
`ifdef YOLCU_SAYAC_EN
          hizmet_d = hizmet_q + 8'd1;
`endif
          if (!fifo_bos) begin
            fifo_oku = 1'b1;
            yukle    = 1'b1;
          end else if (bus.yaz) begin
            atla        = 1'b1;
            yukle       = 1'b1;
            yukle_kaydi = giris_kaydi;
          end else begin
            durum_d   = BOS;
            gecerli_d = 1'b0;
            kimlik_d  = '0;
            uyruk_d   = 1'b0;
            agirlik_d = '0;
            bakiye_d  = '0;
          end
        end
      end
      default: begin
        durum_d = BOS;
      end
    endcase

    // Start of a new round: latch the record and restart the hold counter.
    if (yukle) begin
      {kimlik_d, uyruk_d, agirlik_d, bakiye_d} = yukle_kaydi;
      gecerli_d  = 1'b1;
      tur_basi_d = 1'b1;
      sayac_d    = SAYAC_YUKLE;
      durum_d    = SUNUM;
    end
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q    <= BOS;
      sayac_q    <= 8'd0;
      kimlik_q   <= '0;
      uyruk_q    <= 1'b0;
      agirlik_q  <= '0;
      bakiye_q   <= '0;
      gecerli_q  <= 1'b0;
      tur_basi_q <= 1'b0;
      tasma_q    <= 1'b0;
    end else begin
      durum_q    <= durum_d;
      sayac_q    <= sayac_d;
      kimlik_q   <= kimlik_d;
      uyruk_q    <= uyruk_d;
      agirlik_q  <= agirlik_d;
      bakiye_q   <= bakiye_d;
      gecerli_q  <= gecerli_d;
      tur_basi_q <= tur_basi_d;
      tasma_q    <= tasma_d;
    end
  end

`ifdef YOLCU_SAYAC_EN
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      hizmet_q <= 8'd0;
    end else begin
      hizmet_q <= hizmet_d;
    end
  end

  assign bus.hizmet_sayisi = hizmet_q;
`else
  assign bus.hizmet_sayisi = 8'd0;
`endif

  assign bus.dolu          = fifo_dolu;
  assign bus.bos           = fifo_bos;
  assign bus.doluluk       = fifo_doluluk;
  assign bus.kimlik_no     = kimlik_q;
  assign bus.uyruk         = uyruk_q;
  assign bus.agirlik       = agirlik_q;
  assign bus.bakiye        = bakiye_q;
  assign bus.yolcu_gecerli = gecerli_q;
  assign bus.tur_basi      = tur_basi_q;
  assign bus.tasma         = tasma_q;

endmodule

// File: tb/tb_yolcu_sirasi.sv
// tb/tb_yolcu_sirasi.sv - directed self-checking bench for the passenger queue

module tb_yolcu_sirasi;

`ifdef YOLCU_SAYAC_EN
  localparam bit SAYAC_VAR = 1'b1;
`else
  localparam bit SAYAC_VAR = 1'b0;
`endif

  logic saat  = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [5:0] t2_kimlik [3];

  always #5 saat = ~saat;

  yolcu_sirasi_if #(.BIT(6), .DERINLIK_LOG2(2)) bus ();

  yolcu_sirasi #(
    .BIT           (6),
    .DERINLIK_LOG2 (2),
    .TUR_SURESI    (4)
  ) dut (
    .saat  (saat),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] hizmet_bek(input int n);
    return SAYAC_VAR ? 32'(n) : 32'd0;
  endfunction

  task automatic adim();
    @(posedge saat);
    #1;
  endtask

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    checks++;
    assert (gozlenen === beklenen) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic kayit_ver(input logic [5:0] k, input logic u, input logic [5:0] a, input logic [8:0] b);
    bus.yaz         = 1'b1;
    bus.kimlik_no_g = k;
    bus.uyruk_g     = u;
    bus.agirlik_g   = a;
    bus.bakiye_g    = b;
  endtask

  task automatic yaz_birak();
    bus.yaz = 1'b0;
  endtask

  task automatic sifirla();
    reset = 1'b0;
    adim();
    adim();
    reset = 1'b1;
    adim();
  endtask

  task automatic sunum(input string etiket, input logic [5:0] k, input logic tb);
    kontrol({etiket, "_gecerli"}, bus.yolcu_gecerli, 1);
    kontrol({etiket, "_tur_basi"}, bus.tur_basi, tb);
    kontrol({etiket, "_kimlik"}, bus.kimlik_no, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    t2_kimlik = '{6'd1, 6'd2, 6'd3};
    bus.yaz = 1'b0;
    bus.kimlik_no_g = '0;
    bus.uyruk_g = 1'b0;
    bus.agirlik_g = '0;
    bus.bakiye_g = '0;

    // Reset state
    reset = 1'b0;
    adim();
    adim();
    kontrol("rst_gecerli", bus.yolcu_gecerli, 0);
    kontrol("rst_bos", bus.bos, 1);
    kontrol("rst_dolu", bus.dolu, 0);
    kontrol("rst_doluluk", bus.doluluk, 0);
    kontrol("rst_tasma", bus.tasma, 0);
    kontrol("rst_hizmet", bus.hizmet_sayisi, 0);
    kontrol("rst_tur_basi", bus.tur_basi, 0);
    kontrol("rst_kimlik", bus.kimlik_no, 0);
    kontrol("rst_bakiye", bus.bakiye, 0);
    reset = 1'b1;
    adim();

    // Test 1: single record, 4-cycle presentation
    kayit_ver(6'd5, 1'b1, 6'd20, 9'd300);
    adim();
    yaz_birak();
    kontrol("t1_n_gecerli", bus.yolcu_gecerli, 0);
    kontrol("t1_n_doluluk", bus.doluluk, 1);
    adim();
    sunum("t1_n1", 6'd5, 1'b1);
    kontrol("t1_n1_uyruk", bus.uyruk, 1);
    kontrol("t1_n1_agirlik", bus.agirlik, 20);
    kontrol("t1_n1_bakiye", bus.bakiye, 300);
    kontrol("t1_n1_doluluk", bus.doluluk, 0);
    kontrol("t1_n1_bos", bus.bos, 1);
    for (int i = 2; i <= 4; i++) begin
      adim();
      sunum("t1_hold", 6'd5, 1'b0);
      kontrol("t1_hold_bakiye", bus.bakiye, 300);
    end
    adim();
    kontrol("t1_end_gecerli", bus.yolcu_gecerli, 0);
    kontrol("t1_end_kimlik", bus.kimlik_no, 0);
    kontrol("t1_end_uyruk", bus.uyruk, 0);
    kontrol("t1_end_agirlik", bus.agirlik, 0);
    kontrol("t1_end_bakiye", bus.bakiye, 0);
    kontrol("t1_end_tur_basi", bus.tur_basi, 0);
    kontrol("t1_end_hizmet", bus.hizmet_sayisi, hizmet_bek(1));

    // Test 2: three records back-to-back
    sifirla();
    kayit_ver(6'd1, 1'b0, 6'd10, 9'd100);
    adim();
    kayit_ver(6'd2, 1'b1, 6'd11, 9'd200);
    adim();
    sunum("t2_k1", 6'd1, 1'b1);
    kayit_ver(6'd3, 1'b0, 6'd12, 9'd511);
    adim();
    yaz_birak();
    sunum("t2_k2", 6'd1, 1'b0);
    kontrol("t2_k2_doluluk", bus.doluluk, 2);
    for (int k = 3; k <= 12; k++) begin
      adim();
      sunum("t2_seq", t2_kimlik[(k - 1) / 4], (k % 4) == 1);
      if (k == 9) kontrol("t2_c_bakiye", bus.bakiye, 511);
    end
    adim();
    kontrol("t2_end_gecerli", bus.yolcu_gecerli, 0);
    kontrol("t2_end_hizmet", bus.hizmet_sayisi, hizmet_bek(3));

    // Test 3: overflow while presenting
    sifirla();
    kayit_ver(6'd10, 1'b1, 6'd5, 9'd50);
    adim();
    for (int i = 0; i < 4; i++) begin
      kayit_ver(6'(11 + i), 1'b0, 6'(i), 9'(i));
      adim();
    end
    sunum("t3_r", 6'd10, 1'b0);
    kontrol("t3_full_doluluk", bus.doluluk, 4);
    kontrol("t3_full_dolu", bus.dolu, 1);
    kontrol("t3_full_tasma", bus.tasma, 0);
    kayit_ver(6'd15, 1'b0, 6'd9, 9'd9);
    adim();
    yaz_birak();
    kontrol("t3_tasma", bus.tasma, 1);
    kontrol("t3_dolu_after_pop", bus.dolu, 0);
    kontrol("t3_doluluk_after_pop", bus.doluluk, 3);
    sunum("t3_q0", 6'd11, 1'b1);
    for (int r = 1; r <= 3; r++) begin
      repeat (4) adim();
      sunum("t3_q", 6'(11 + r), 1'b1);
      kontrol("t3_q_doluluk", bus.doluluk, 32'(3 - r));
    end
    repeat (4) adim();
    kontrol("t3_end_gecerli", bus.yolcu_gecerli, 0);
    kontrol("t3_end_hizmet", bus.hizmet_sayisi, hizmet_bek(5));
    kontrol("t3_end_tasma", bus.tasma, 1);

    // Test 4: write on the pop edge, then a write into an empty FIFO at round end
    sifirla();
    kayit_ver(6'd20, 1'b0, 6'd1, 9'd1);
    adim();
    kayit_ver(6'd21, 1'b1, 6'd2, 9'd2);
    adim();
    yaz_birak();
    sunum("t4_p", 6'd20, 1'b1);
    kontrol("t4_p_doluluk", bus.doluluk, 1);
    repeat (3) adim();
    sunum("t4_p_last", 6'd20, 1'b0);
    kontrol("t4_p_last_doluluk", bus.doluluk, 1);
    kayit_ver(6'd22, 1'b0, 6'd3, 9'd3);
    adim();
    yaz_birak();
    sunum("t4_q", 6'd21, 1'b1);
    kontrol("t4_q_doluluk", bus.doluluk, 1);
    repeat (4) adim();
    sunum("t4_r", 6'd22, 1'b1);
    kontrol("t4_r_doluluk", bus.doluluk, 0);
    kontrol("t4_r_bos", bus.bos, 1);
    repeat (3) adim();
    kayit_ver(6'd23, 1'b1, 6'd33, 9'd444);
    adim();
    yaz_birak();
    sunum("t4_s", 6'd23, 1'b1);
    kontrol("t4_s_bakiye", bus.bakiye, 444);
    kontrol("t4_s_doluluk", bus.doluluk, 0);
    kontrol("t4_s_bos", bus.bos, 1);
    repeat (4) adim();
    kontrol("t4_end_gecerli", bus.yolcu_gecerli, 0);
    kontrol("t4_end_hizmet", bus.hizmet_sayisi, hizmet_bek(4));

    // Test 5: asynchronous reset in the 2nd cycle of a round
    sifirla();
    kayit_ver(6'd30, 1'b1, 6'd7, 9'd70);
    adim();
    kayit_ver(6'd31, 1'b0, 6'd8, 9'd80);
    adim();
    yaz_birak();
    adim();
    sunum("t5_second", 6'd30, 1'b0);
    kontrol("t5_second_doluluk", bus.doluluk, 1);
    reset = 1'b0;
    #1;
    kontrol("t5_rst_gecerli", bus.yolcu_gecerli, 0);
    kontrol("t5_rst_kimlik", bus.kimlik_no, 0);
    kontrol("t5_rst_bakiye", bus.bakiye, 0);
    kontrol("t5_rst_bos", bus.bos, 1);
    kontrol("t5_rst_doluluk", bus.doluluk, 0);
    kontrol("t5_rst_tur_basi", bus.tur_basi, 0);
    adim();
    reset = 1'b1;
    kayit_ver(6'd32, 1'b1, 6'd9, 9'd90);
    adim();
    yaz_birak();
    kontrol("t5_m_gecerli", bus.yolcu_gecerli, 0);
    kontrol("t5_m_doluluk", bus.doluluk, 1);
    adim();
    sunum("t5_new", 6'd32, 1'b1);
    kontrol("t5_new_bakiye", bus.bakiye, 90);
    repeat (4) adim();
    kontrol("t5_end_gecerli", bus.yolcu_gecerli, 0);
    kontrol("t5_end_hizmet", bus.hizmet_sayisi, hizmet_bek(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
